// File: rtl/led_drv_pkg.sv
// led_drv_pkg: constants and types shared by the LED-driver serial blocks.
//   LATCH_SIZE           bits per driver latch frame (MSB = latch-select)
//   NUM_DRIVERS_CHAINED  frames expected between two LAT pulses
//   *_LSB                bit offsets of the control-frame fields
//   ctrl_fields_t        decoded control-frame fields
//   dc_mismatch()        1 when any dot-correction field differs from field 0
package led_drv_pkg;

    localparam int LATCH_SIZE          = 769;
    localparam int NUM_DRIVERS_CHAINED = 2;

    localparam int DC_W     = 7;
    localparam int DC_NUM   = 48;
    localparam int MC_W     = 3;
    localparam int BC_W     = 7;
    localparam int FC_W     = 5;

    localparam int MC_LSB   = 336;
    localparam int BC_LSB   = 345;
    localparam int FC_LSB   = 366;
    localparam int LSEL_BIT = 768;

    typedef struct packed {
        logic [MC_W-1:0] mc_r;
        logic [MC_W-1:0] mc_g;
        logic [MC_W-1:0] mc_b;
        logic [BC_W-1:0] gbc_r;
        logic [BC_W-1:0] gbc_g;
        logic [BC_W-1:0] gbc_b;
        logic [FC_W-1:0] fc;
    } ctrl_fields_t;

    // Dot-correction fields occupy bits DC_NUM*DC_W-1:0; a healthy control
    // frame written by the transmitter carries the same value in every field.
    function automatic logic dc_mismatch(input logic [LATCH_SIZE-1:0] d);
        logic m;
        m = 1'b0;
        for (int i = 1; i < DC_NUM; i++) begin
            if (d[i*DC_W +: DC_W] != d[DC_W-1:0]) m = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/led_ctrl_field_decode.sv
// led_ctrl_field_decode: purely combinational slicing of a control frame.
//   frame_data  in   LATCH_SIZE  assembled latch frame
//   fields      out  ctrl_fields_t  mc / gbc / fc fields
//   dc_err      out  1           dot-correction fields are not uniform
module led_ctrl_field_decode
    import led_drv_pkg::*;
(
    input  logic [LATCH_SIZE-1:0] frame_data,
    output ctrl_fields_t          fields,
    output logic                  dc_err
);

    always_comb begin
        fields.mc_r  = frame_data[MC_LSB          +: MC_W];
        fields.mc_g  = frame_data[MC_LSB + MC_W   +: MC_W];
        fields.mc_b  = frame_data[MC_LSB + 2*MC_W +: MC_W];
        fields.gbc_r = frame_data[BC_LSB          +: BC_W];
        fields.gbc_g = frame_data[BC_LSB + BC_W   +: BC_W];
        fields.gbc_b = frame_data[BC_LSB + 2*BC_W +: BC_W];
        fields.fc    = frame_data[FC_LSB          +: FC_W];
    end

    assign dc_err = dc_mismatch(frame_data);

    // Bits above the FC field (incl. latch-select) carry nothing to decode.
    logic unused_hi;
    assign unused_hi = ^frame_data[LATCH_SIZE-1:FC_LSB+FC_W];

endmodule

// File: rtl/led_sout_deserializer.sv
// led_sout_deserializer: rebuilds latch frames from the returned LED-driver
// daisy chain (SDI/SCLK/LAT, all launched in the TESTCLK domain), MSB first.
//   TESTCLK, nReset   clock, synchronous active-low reset
//   SCLK, LAT, SDI    serial line; SCLK/LAT are edge-detected, not clocks
//   frame_data/valid/idx/is_ctrl   last completed frame and its pulse
//   latch_valid/latch_count        LAT event pulse and wrapping count
//   err_partial/err_frames/err_clr sticky framing errors and their clear
// Optional macro LED_CTRL_DECODE_EN adds registered control-frame fields
// (mc_r/g/b, gbc_r/g/b, fc, dc_err), loaded on each control frame.
module led_sout_deserializer #(
    parameter int LATCH_SIZE          = led_drv_pkg::LATCH_SIZE,
    parameter int NUM_DRIVERS_CHAINED = led_drv_pkg::NUM_DRIVERS_CHAINED,
    parameter int CNT_W               = 16
) (
    input  logic                  TESTCLK,
    input  logic                  nReset,
    input  logic                  SCLK,
    input  logic                  LAT,
    input  logic                  SDI,
    output logic [LATCH_SIZE-1:0] frame_data,
    output logic                  frame_valid,
    output logic [1:0]            frame_idx,
    output logic                  frame_is_ctrl,
    output logic                  latch_valid,
    output logic [CNT_W-1:0]      latch_count,
    output logic                  err_partial,
    output logic                  err_frames,
    input  logic                  err_clr
`ifdef LED_CTRL_DECODE_EN
    ,
    output logic [2:0]            mc_r,
    output logic [2:0]            mc_g,
    output logic [2:0]            mc_b,
    output logic [6:0]            gbc_r,
    output logic [6:0]            gbc_g,
    output logic [6:0]            gbc_b,
    output logic [4:0]            fc,
    output logic                  dc_err
`endif
);

    import led_drv_pkg::*;

    localparam int BIT_W = $clog2(LATCH_SIZE);

    logic                  sclk_q, lat_q;
    logic                  sclk_rise, lat_rise;
    logic [LATCH_SIZE-1:0] shreg, shreg_sh;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_sh;
    logic [1:0]            frm_cnt, frm_cnt_sh;
    logic                  frame_done;

    assign sclk_rise = SCLK & ~sclk_q;
    assign lat_rise  = LAT  & ~lat_q;

    // State after this cycle's shift only. LAT checks look at these values so
    // a bit arriving together with LAT is counted before the checks run.
    always_comb begin
        shreg_sh   = shreg;
        bit_cnt_sh = bit_cnt;
        frm_cnt_sh = frm_cnt;
        frame_done = 1'b0;
        if (sclk_rise) begin
            shreg_sh = {shreg[LATCH_SIZE-2:0], SDI};
            if (bit_cnt == BIT_W'(LATCH_SIZE-1)) begin
                frame_done = 1'b1;
                bit_cnt_sh = '0;
                if (frm_cnt != 2'd3) frm_cnt_sh = frm_cnt + 2'd1;
            end else begin
                bit_cnt_sh = bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            sclk_q  <= 1'b0;
            lat_q   <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            frm_cnt <= '0;
        end else begin
            sclk_q <= SCLK;
            lat_q  <= LAT;
            if (lat_rise) begin
                shreg   <= '0;
                bit_cnt <= '0;
                frm_cnt <= '0;
            end else begin
                shreg   <= shreg_sh;
                bit_cnt <= bit_cnt_sh;
                frm_cnt <= frm_cnt_sh;
            end
        end
    end

    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            frame_data    <= '0;
            frame_valid   <= 1'b0;
            frame_idx     <= '0;
            frame_is_ctrl <= 1'b0;
            latch_valid   <= 1'b0;
            latch_count   <= '0;
            err_partial   <= 1'b0;
            err_frames    <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            latch_valid <= lat_rise;
            if (frame_done) begin
                frame_data    <= shreg_sh;
                frame_idx     <= frm_cnt;
                frame_is_ctrl <= shreg_sh[LATCH_SIZE-1];
            end
            if (lat_rise) latch_count <= latch_count + CNT_W'(1);
            // Clear first, set last: a new error beats a same-cycle clear.
            err_partial <= (err_partial & ~err_clr) |
                           (lat_rise & (bit_cnt_sh != '0));
            err_frames  <= (err_frames & ~err_clr) |
                           (lat_rise & (frm_cnt_sh != 2'(NUM_DRIVERS_CHAINED)));
        end
    end

`ifdef LED_CTRL_DECODE_EN
    ctrl_fields_t dec_fields;
    logic         dec_dc_err;

    led_ctrl_field_decode u_decode (
        .frame_data (frame_data),
        .fields     (dec_fields),
        .dc_err     (dec_dc_err)
    );

    // Loaded while frame_valid is high, so the fields appear one cycle later.
    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            mc_r   <= '0;
            mc_g   <= '0;
            mc_b   <= '0;
            gbc_r  <= '0;
            gbc_g  <= '0;
            gbc_b  <= '0;
            fc     <= '0;
            dc_err <= 1'b0;
        end else if (frame_valid && frame_is_ctrl) begin
            mc_r   <= dec_fields.mc_r;
            mc_g   <= dec_fields.mc_g;
            mc_b   <= dec_fields.mc_b;
            gbc_r  <= dec_fields.gbc_r;
            gbc_g  <= dec_fields.gbc_g;
            gbc_b  <= dec_fields.gbc_b;
            fc     <= dec_fields.fc;
            dc_err <= dec_dc_err;
        end
    end
`endif

endmodule

// File: tb/tb_led_sout_deserializer.sv
// Directed bench for led_sout_deserializer. Inputs change on the falling
// edge of TESTCLK; outputs are sampled on the falling edge as well.
module tb_led_sout_deserializer;

    localparam int LS = 769;

    logic          TESTCLK = 1'b0;
    logic          nReset  = 1'b0;
    logic          SCLK    = 1'b0;
    logic          LAT     = 1'b0;
    logic          SDI     = 1'b0;
    logic          err_clr = 1'b0;
    logic [LS-1:0] frame_data;
    logic          frame_valid;
    logic [1:0]    frame_idx;
    logic          frame_is_ctrl;
    logic          latch_valid;
    logic [15:0]   latch_count;
    logic          err_partial;
    logic          err_frames;
`ifdef LED_CTRL_DECODE_EN
    logic [2:0]    mc_r, mc_g, mc_b;
    logic [6:0]    gbc_r, gbc_g, gbc_b;
    logic [4:0]    fc;
    logic          dc_err;
`endif

    led_sout_deserializer dut (
        .TESTCLK       (TESTCLK),
        .nReset        (nReset),
        .SCLK          (SCLK),
        .LAT           (LAT),
        .SDI           (SDI),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .frame_idx     (frame_idx),
        .frame_is_ctrl (frame_is_ctrl),
        .latch_valid   (latch_valid),
        .latch_count   (latch_count),
        .err_partial   (err_partial),
        .err_frames    (err_frames),
        .err_clr       (err_clr)
`ifdef LED_CTRL_DECODE_EN
        ,
        .mc_r          (mc_r),
        .mc_g          (mc_g),
        .mc_b          (mc_b),
        .gbc_r         (gbc_r),
        .gbc_g         (gbc_g),
        .gbc_b         (gbc_b),
        .fc            (fc),
        .dc_err        (dc_err)
`endif
    );

    always #5 TESTCLK = ~TESTCLK;

    int checks = 0;
    int errors = 0;

    // Pulse monitor: logs every frame and counts latch pulses, coincident
    // pulses and any pulse that stays high for two samples in a row.
    int            fv_cnt = 0, lv_cnt = 0, both_cnt = 0, stretch_cnt = 0;
    logic [LS-1:0] data_log [16];
    logic [1:0]    idx_log  [16];
    logic          ctrl_log [16];
    logic          fv_d = 1'b0, lv_d = 1'b0;

    always @(negedge TESTCLK) begin
        if (frame_valid) begin
            data_log[fv_cnt % 16] <= frame_data;
            idx_log[fv_cnt % 16]  <= frame_idx;
            ctrl_log[fv_cnt % 16] <= frame_is_ctrl;
            fv_cnt <= fv_cnt + 1;
        end
        if (latch_valid) lv_cnt <= lv_cnt + 1;
        if (frame_valid && latch_valid) both_cnt <= both_cnt + 1;
        if ((frame_valid && fv_d) || (latch_valid && lv_d)) stretch_cnt <= stretch_cnt + 1;
        fv_d <= frame_valid;
        lv_d <= latch_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge TESTCLK);
    endtask

    task automatic send_bit(input logic b, input int hold);
        @(negedge TESTCLK);
        SDI  = b;
        SCLK = 1'b1;
        repeat (hold - 1) @(negedge TESTCLK);
        @(negedge TESTCLK);
        SCLK = 1'b0;
    endtask

    // Sends the top n bits of f, MSB first; the first bit may hold SCLK high.
    task automatic send_bits(input logic [LS-1:0] f, input int n, input int first_hold);
        for (int i = 0; i < n; i++)
            send_bit(f[LS-1-i], (i == 0) ? first_hold : 1);
    endtask

    task automatic pulse_lat();
        @(negedge TESTCLK);
        LAT = 1'b1;
        @(negedge TESTCLK);
        LAT = 1'b0;
        tick(2);
    endtask

    task automatic clear_errs();
        @(negedge TESTCLK);
        err_clr = 1'b1;
        @(negedge TESTCLK);
        err_clr = 1'b0;
        tick(1);
    endtask

    // Control frame: latch-select set, uniform DC fields 0x55 (field 20 bent
    // when dc_bad), FC bits 366..370 = 1,1,0,1,1.
    function automatic logic [LS-1:0] ctrl_frame(input logic [2:0] mc, input logic [6:0] gbc,
                                                 input logic dc_bad);
        logic [LS-1:0] f;
        f = '0;
        for (int i = 0; i < 48; i++) f[i*7 +: 7] = 7'h55;
        if (dc_bad) f[20*7 +: 7] = 7'h2A;
        f[338:336] = mc;
        f[351:345] = gbc;
        f[370:366] = 5'b11011;
        f[768]     = 1'b1;
        return f;
    endfunction

    // Grayscale frame: 16 groups of 48 bits, red at +0, green at +16.
    function automatic logic [LS-1:0] gray_frame(input int off);
        logic [LS-1:0] f;
        f = '0;
        for (int g = 0; g < 16; g++) f[g*48 + off +: 16] = 16'h8001;
        return f;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        nReset = 1'b0;
        tick(3);
        nReset = 1'b1;
        tick(2);
        checks++; if (frame_data !== '0) begin errors++; $display("FAIL reset_frame_data: got %0h expected 0", frame_data); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %0b expected 0", frame_valid); end
        checks++; if (frame_idx !== 2'd0) begin errors++; $display("FAIL reset_frame_idx: got %0d expected 0", frame_idx); end
        checks++; if (frame_is_ctrl !== 1'b0) begin errors++; $display("FAIL reset_is_ctrl: got %0b expected 0", frame_is_ctrl); end
        checks++; if (latch_valid !== 1'b0) begin errors++; $display("FAIL reset_latch_valid: got %0b expected 0", latch_valid); end
        checks++; if (latch_count !== 16'd0) begin errors++; $display("FAIL reset_latch_count: got %0d expected 0", latch_count); end
        checks++; if (err_partial !== 1'b0) begin errors++; $display("FAIL reset_err_partial: got %0b expected 0", err_partial); end
        checks++; if (err_frames !== 1'b0) begin errors++; $display("FAIL reset_err_frames: got %0b expected 0", err_frames); end
`ifdef LED_CTRL_DECODE_EN
        checks++; if ({mc_r, gbc_r, fc, dc_err} !== '0) begin errors++; $display("FAIL reset_decode: got %0h expected 0", {mc_r, gbc_r, fc, dc_err}); end
`endif
    endtask

    task automatic test_ctrl_frame();
        logic [LS-1:0] f;
        int f0, l0;
        f  = ctrl_frame(3'd5, 7'd127, 1'b0);
        f0 = fv_cnt;
        l0 = lv_cnt;
        send_bits(f, LS, 1);
        tick(2);
        pulse_lat();
        checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL ctrl_frame_count: got %0d expected 1", fv_cnt - f0); end
        checks++; if (ctrl_log[f0 % 16] !== 1'b1) begin errors++; $display("FAIL ctrl_is_ctrl: got %0b expected 1", ctrl_log[f0 % 16]); end
        checks++; if (idx_log[f0 % 16] !== 2'd0) begin errors++; $display("FAIL ctrl_idx: got %0d expected 0", idx_log[f0 % 16]); end
        checks++; if (data_log[f0 % 16] !== f) begin errors++; $display("FAIL ctrl_data: got %0h expected %0h", data_log[f0 % 16], f); end
        checks++; if (lv_cnt - l0 !== 1) begin errors++; $display("FAIL ctrl_latch_pulses: got %0d expected 1", lv_cnt - l0); end
        checks++; if (latch_count !== 16'd1) begin errors++; $display("FAIL ctrl_latch_count: got %0d expected 1", latch_count); end
        checks++; if (err_partial !== 1'b0) begin errors++; $display("FAIL ctrl_err_partial: got %0b expected 0", err_partial); end
        checks++; if (err_frames !== 1'b1) begin errors++; $display("FAIL ctrl_err_frames: got %0b expected 1", err_frames); end
`ifdef LED_CTRL_DECODE_EN
        checks++; if (mc_r !== 3'd5) begin errors++; $display("FAIL dec_mc_r: got %0d expected 5", mc_r); end
        checks++; if (gbc_r !== 7'd127) begin errors++; $display("FAIL dec_gbc_r: got %0d expected 127", gbc_r); end
        checks++; if (fc !== 5'b11011) begin errors++; $display("FAIL dec_fc: got %0b expected 11011", fc); end
        checks++; if (dc_err !== 1'b0) begin errors++; $display("FAIL dec_dc_err_uniform: got %0b expected 0", dc_err); end
`endif
    endtask

    task automatic test_grayscale();
        logic [LS-1:0] g0, g1;
        int f0;
        clear_errs();
        g0 = gray_frame(0);
        g1 = gray_frame(16);
        f0 = fv_cnt;
        send_bits(g0, LS, 4);   // first bit keeps SCLK high for 4 cycles
        send_bits(g1, LS, 1);
        tick(2);
        pulse_lat();
        checks++; if (fv_cnt - f0 !== 2) begin errors++; $display("FAIL gray_frame_count: got %0d expected 2", fv_cnt - f0); end
        checks++; if (idx_log[f0 % 16] !== 2'd0) begin errors++; $display("FAIL gray_idx0: got %0d expected 0", idx_log[f0 % 16]); end
        checks++; if (idx_log[(f0+1) % 16] !== 2'd1) begin errors++; $display("FAIL gray_idx1: got %0d expected 1", idx_log[(f0+1) % 16]); end
        checks++; if ({ctrl_log[f0 % 16], ctrl_log[(f0+1) % 16]} !== 2'b00) begin errors++; $display("FAIL gray_is_ctrl: got %0b%0b expected 00", ctrl_log[f0 % 16], ctrl_log[(f0+1) % 16]); end
        checks++; if (data_log[f0 % 16] !== g0) begin errors++; $display("FAIL gray_data0: got %0h expected %0h", data_log[f0 % 16], g0); end
        checks++; if (data_log[(f0+1) % 16] !== g1) begin errors++; $display("FAIL gray_data1: got %0h expected %0h", data_log[(f0+1) % 16], g1); end
        checks++; if (latch_count !== 16'd2) begin errors++; $display("FAIL gray_latch_count: got %0d expected 2", latch_count); end
        checks++; if ({err_partial, err_frames} !== 2'b00) begin errors++; $display("FAIL gray_errors: got %0b%0b expected 00", err_partial, err_frames); end
`ifdef LED_CTRL_DECODE_EN
        checks++; if (mc_r !== 3'd5) begin errors++; $display("FAIL gray_dec_hold: got %0d expected 5", mc_r); end
`endif
    endtask

    task automatic test_short_frame();
        int f0;
        f0 = fv_cnt;
        send_bits(gray_frame(0), 500, 1);
        tick(2);
        pulse_lat();
        checks++; if (fv_cnt - f0 !== 0) begin errors++; $display("FAIL short_no_frame: got %0d expected 0", fv_cnt - f0); end
        checks++; if (err_partial !== 1'b1) begin errors++; $display("FAIL short_err_partial: got %0b expected 1", err_partial); end
        checks++; if (err_frames !== 1'b1) begin errors++; $display("FAIL short_err_frames: got %0b expected 1", err_frames); end
        checks++; if (latch_count !== 16'd3) begin errors++; $display("FAIL short_latch_count: got %0d expected 3", latch_count); end
        clear_errs();
        checks++; if ({err_partial, err_frames} !== 2'b00) begin errors++; $display("FAIL short_err_clr: got %0b%0b expected 00", err_partial, err_frames); end
        // err_clr lands on the same edge that records a new partial-frame error
        send_bits(gray_frame(0), 5, 1);
        @(negedge TESTCLK);
        LAT = 1'b1;
        err_clr = 1'b1;
        @(negedge TESTCLK);
        LAT = 1'b0;
        err_clr = 1'b0;
        tick(2);
        checks++; if (err_partial !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %0b expected 1", err_partial); end
        checks++; if (latch_count !== 16'd4) begin errors++; $display("FAIL setclr_latch_count: got %0d expected 4", latch_count); end
        clear_errs();
    endtask

    task automatic test_same_cycle();
        logic [LS-1:0] g0, g1;
        int f0, b0;
        g0 = gray_frame(0);
        g1 = gray_frame(16);
        f0 = fv_cnt;
        b0 = both_cnt;
        send_bits(g0, LS, 1);
        send_bits(g1, LS-1, 1);
        @(negedge TESTCLK);
        SDI  = g1[0];
        SCLK = 1'b1;
        LAT  = 1'b1;
        @(negedge TESTCLK);
        SCLK = 1'b0;
        LAT  = 1'b0;
        tick(3);
        checks++; if (both_cnt - b0 !== 1) begin errors++; $display("FAIL same_cycle_pulses: got %0d expected 1", both_cnt - b0); end
        checks++; if (fv_cnt - f0 !== 2) begin errors++; $display("FAIL same_frame_count: got %0d expected 2", fv_cnt - f0); end
        checks++; if (data_log[(f0+1) % 16] !== g1) begin errors++; $display("FAIL same_data: got %0h expected %0h", data_log[(f0+1) % 16], g1); end
        checks++; if (err_partial !== 1'b0) begin errors++; $display("FAIL same_err_partial: got %0b expected 0", err_partial); end
        checks++; if (err_frames !== 1'b0) begin errors++; $display("FAIL same_err_frames: got %0b expected 0", err_frames); end
        checks++; if (latch_count !== 16'd5) begin errors++; $display("FAIL same_latch_count: got %0d expected 5", latch_count); end
        checks++; if (stretch_cnt !== 0) begin errors++; $display("FAIL pulse_stretch: got %0d expected 0", stretch_cnt); end
    endtask

    task automatic test_reset_mid_shift();
        logic [LS-1:0] g1;
        int f0;
        g1 = gray_frame(16);
        send_bits(ctrl_frame(3'd5, 7'd127, 1'b0), 300, 1);
        @(negedge TESTCLK);
        nReset = 1'b0;
        tick(2);
        nReset = 1'b1;
        tick(1);
        checks++; if (latch_count !== 16'd0) begin errors++; $display("FAIL midrst_latch_count: got %0d expected 0", latch_count); end
        checks++; if ({err_partial, err_frames} !== 2'b00) begin errors++; $display("FAIL midrst_errors: got %0b%0b expected 00", err_partial, err_frames); end
        f0 = fv_cnt;
        send_bits(g1, LS, 1);
        tick(2);
        checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL midrst_frame_count: got %0d expected 1", fv_cnt - f0); end
        checks++; if (data_log[f0 % 16] !== g1) begin errors++; $display("FAIL midrst_data: got %0h expected %0h", data_log[f0 % 16], g1); end
        checks++; if (idx_log[f0 % 16] !== 2'd0) begin errors++; $display("FAIL midrst_idx: got %0d expected 0", idx_log[f0 % 16]); end
        checks++; if ({err_partial, err_frames} !== 2'b00) begin errors++; $display("FAIL midrst_errors_after: got %0b%0b expected 00", err_partial, err_frames); end
    endtask

`ifdef LED_CTRL_DECODE_EN
    task automatic test_dc_err();
        send_bits(ctrl_frame(3'd2, 7'd1, 1'b1), LS, 1);
        tick(3);
        checks++; if (dc_err !== 1'b1) begin errors++; $display("FAIL dec_dc_err_bent: got %0b expected 1", dc_err); end
        checks++; if (mc_r !== 3'd2) begin errors++; $display("FAIL dec_mc_r2: got %0d expected 2", mc_r); end
        checks++; if (gbc_r !== 7'd1) begin errors++; $display("FAIL dec_gbc_r1: got %0d expected 1", gbc_r); end
    endtask
`endif

    initial begin
        test_reset();
        test_ctrl_frame();
        test_grayscale();
        test_short_frame();
        test_same_cycle();
        test_reset_mid_shift();
`ifdef LED_CTRL_DECODE_EN
        test_dc_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
